rtc_calendar_counter: RTL and testbench

Free-running real-time clock/calendar that consumes the time-setting interface (year_d, month_d, day_d, week, hour_d, min_d, sec_d) produced by the set-time UI.
- On a load strobe it captures the set values.
- It then advances them once per second, derived from the system clock.
- It provides the current date/time to the display path.
- It is the reader/consumer end of the set-time bus.

---
 rtl/rtc_pkg.sv | 24 ++
 rtl/rtc_days_in_month.sv | 20 ++
 rtl/rtc_calendar_counter.sv | 164 ++++++++++++++++
 tb/tb_rtc_calendar_counter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared widths, field limits and calendar helpers for the RTC calendar counter.
package rtc_pkg;

  localparam int YEAR_W  = 15;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int WEEK_W  = 4;
  localparam int HMS_W   = 6;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HOUR_MAX  = 23;
  localparam int MONTH_MAX = 12;
  localparam int WEEK_MAX  = 6;

  // 2000-01-01 fell on a Saturday (0 = Sunday).
  localparam int RST_WEEK = 6;

  // Gregorian leap-year rule.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return ((y[1:0] == 2'd0) && ((y % 15'd100) != 15'd0)) || ((y % 15'd400) == 15'd0);
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational month-length lookup; February follows the leap-year rule.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   days
);

  // Month length; out-of-range months fall back to 31 (callers sanitise first).
  always_comb begin
    days = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = is_leap(year) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
  end

endmodule

// File: rtl/rtc_calendar_counter.sv
// Free-running calendar clock: loads a sanitised set time, then advances it
// once per CLK_HZ clock cycles with a full sec->year carry cascade.
module rtc_calendar_counter
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int RST_YEAR = 2000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [YEAR_W-1:0]  year_d,
  input  logic [MONTH_W-1:0] month_d,
  input  logic [DAY_W-1:0]   day_d,
  input  logic [WEEK_W-1:0]  week_d,
  input  logic [HMS_W-1:0]   hour_d,
  input  logic [HMS_W-1:0]   min_d,
  input  logic [HMS_W-1:0]   sec_d,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day,
  output logic [WEEK_W-1:0]  week,
  output logic [HMS_W-1:0]   hour,
  output logic [HMS_W-1:0]   min,
  output logic [HMS_W-1:0]   sec,
  output logic               sec_tick
);

  localparam int              PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_TC = PS_W'(CLK_HZ - 1);

  logic [PS_W-1:0]    r_ps;
  logic [YEAR_W-1:0]  r_year;
  logic [MONTH_W-1:0] r_month;
  logic [DAY_W-1:0]   r_day;
  logic [WEEK_W-1:0]  r_week;
  logic [HMS_W-1:0]   r_hour;
  logic [HMS_W-1:0]   r_min;
  logic [HMS_W-1:0]   r_sec;
  logic               r_tick;

  logic               w_event;
  logic [DAY_W-1:0]   w_dim_cur;
  logic [DAY_W-1:0]   w_dim_ld;

  logic [MONTH_W-1:0] w_ld_month;
  logic [DAY_W-1:0]   w_ld_day;
  logic [WEEK_W-1:0]  w_ld_week;
  logic [HMS_W-1:0]   w_ld_hour;
  logic [HMS_W-1:0]   w_ld_min;
  logic [HMS_W-1:0]   w_ld_sec;

  logic               w_sec_c, w_min_c, w_hour_c, w_day_c, w_mon_c;
  logic [YEAR_W-1:0]  w_nx_year;
  logic [MONTH_W-1:0] w_nx_month;
  logic [DAY_W-1:0]   w_nx_day;
  logic [WEEK_W-1:0]  w_nx_week;
  logic [HMS_W-1:0]   w_nx_hour;
  logic [HMS_W-1:0]   w_nx_min;
  logic [HMS_W-1:0]   w_nx_sec;

  // Month length for the running date (drives the day carry).
  rtc_days_in_month u_dim_cur (
    .month (r_month),
    .year  (r_year),
    .days  (w_dim_cur)
  );

  // Month length for the incoming set date (drives the day clamp).
  rtc_days_in_month u_dim_ld (
    .month (w_ld_month),
    .year  (year_d),
    .days  (w_dim_ld)
  );

  assign w_event = run && (r_ps == PS_TC);

  // Clamp the set month into 1..12 before it selects the month length.
  always_comb begin
    w_ld_month = month_d;
    if (month_d == '0)                          w_ld_month = MONTH_W'(1);
    else if (month_d > MONTH_W'(MONTH_MAX))     w_ld_month = MONTH_W'(MONTH_MAX);
  end

  // Clamp day and time-of-day fields; an illegal weekday restarts at Sunday.
  always_comb begin
    w_ld_day  = day_d;
    w_ld_week = week_d;
    w_ld_hour = hour_d;
    w_ld_min  = min_d;
    w_ld_sec  = sec_d;
    if (day_d == '0)                       w_ld_day  = DAY_W'(1);
    else if (day_d > w_dim_ld)             w_ld_day  = w_dim_ld;
    if (week_d > WEEK_W'(WEEK_MAX))        w_ld_week = '0;
    if (hour_d > HMS_W'(HOUR_MAX))         w_ld_hour = HMS_W'(HOUR_MAX);
    if (min_d > HMS_W'(MIN_MAX))           w_ld_min  = HMS_W'(MIN_MAX);
    if (sec_d > HMS_W'(SEC_MAX))           w_ld_sec  = HMS_W'(SEC_MAX);
  end

  // Carry chain: each field rolls over only when every lower field rolls over.
  assign w_sec_c  = (r_sec >= HMS_W'(SEC_MAX));
  assign w_min_c  = w_sec_c  && (r_min  >= HMS_W'(MIN_MAX));
  assign w_hour_c = w_min_c  && (r_hour >= HMS_W'(HOUR_MAX));
  assign w_day_c  = w_hour_c && (r_day  >= w_dim_cur);
  assign w_mon_c  = w_day_c  && (r_month >= MONTH_W'(MONTH_MAX));

  assign w_nx_sec   = w_sec_c  ? '0 : r_sec + HMS_W'(1);
  assign w_nx_min   = w_min_c  ? '0 : (w_sec_c ? r_min + HMS_W'(1) : r_min);
  assign w_nx_hour  = w_hour_c ? '0 : (w_min_c ? r_hour + HMS_W'(1) : r_hour);
  assign w_nx_week  = !w_hour_c ? r_week :
                      ((r_week >= WEEK_W'(WEEK_MAX)) ? '0 : r_week + WEEK_W'(1));
  assign w_nx_day   = w_day_c  ? DAY_W'(1) : (w_hour_c ? r_day + DAY_W'(1) : r_day);
  assign w_nx_month = w_mon_c  ? MONTH_W'(1) : (w_day_c ? r_month + MONTH_W'(1) : r_month);
  // Year rolls 32767 -> 0 through natural 15-bit overflow.
  assign w_nx_year  = w_mon_c  ? r_year + YEAR_W'(1) : r_year;

  // Prescaler and calendar state; a load overrides (and swallows) a same-cycle advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps    <= '0;
      r_year  <= YEAR_W'(RST_YEAR);
      r_month <= MONTH_W'(1);
      r_day   <= DAY_W'(1);
      r_week  <= WEEK_W'(RST_WEEK);
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_tick  <= 1'b0;
    end else if (load) begin
      r_ps    <= '0;
      r_year  <= year_d;
      r_month <= w_ld_month;
      r_day   <= w_ld_day;
      r_week  <= w_ld_week;
      r_hour  <= w_ld_hour;
      r_min   <= w_ld_min;
      r_sec   <= w_ld_sec;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_event;
      if (run) r_ps <= w_event ? '0 : r_ps + PS_W'(1);
      if (w_event) begin
        r_year  <= w_nx_year;
        r_month <= w_nx_month;
        r_day   <= w_nx_day;
        r_week  <= w_nx_week;
        r_hour  <= w_nx_hour;
        r_min   <= w_nx_min;
        r_sec   <= w_nx_sec;
      end
    end
  end

  assign year     = r_year;
  assign month    = r_month;
  assign day      = r_day;
  assign week     = r_week;
  assign hour     = r_hour;
  assign min      = r_min;
  assign sec      = r_sec;
  assign sec_tick = r_tick;

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Bench for rtc_calendar_counter with a 4-cycle second: table-driven load/advance
// vectors, hand-written corner sequences and a randomized run against a
// calendar reference model.
module tb_rtc_calendar_counter;

  localparam int CLK_HZ = 4;

  typedef struct packed {
    int y; int mo; int d; int w; int h; int mi; int s;
  } tm_t;

  typedef struct packed {
    tm_t ld;   // values driven on the set-time bus
    tm_t cap;  // expected right after the load
    tm_t adv;  // expected after one advance
  } vec_t;

  logic        clk, rst_n, load, run;
  logic [14:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  day_d;
  logic [3:0]  week_d;
  logic [5:0]  hour_d, min_d, sec_d;
  logic [14:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [3:0]  week;
  logic [5:0]  hour, min, sec;
  logic        sec_tick;

  int n_vec = 0;
  int n_err = 0;

  rtc_calendar_counter #(.CLK_HZ(CLK_HZ), .RST_YEAR(2000)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .run(run),
    .year_d(year_d), .month_d(month_d), .day_d(day_d), .week_d(week_d),
    .hour_d(hour_d), .min_d(min_d), .sec_d(sec_d),
    .year(year), .month(month), .day(day), .week(week),
    .hour(hour), .min(min), .sec(sec), .sec_tick(sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tm_t mk(int y, int mo, int d, int w, int h, int mi, int s);
    tm_t t;
    t.y = y; t.mo = mo; t.d = d; t.w = w; t.h = h; t.mi = mi; t.s = s;
    return t;
  endfunction

  // ---------------- reference calendar model ----------------
  function automatic bit leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int mdays(int mo, int y);
    int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && leap(y)) return 29;
    return tbl[mo-1];
  endfunction

  function automatic tm_t sanitize(tm_t t);
    tm_t r = t;
    int dm;
    if (r.mo < 1) r.mo = 1;
    if (r.mo > 12) r.mo = 12;
    dm = mdays(r.mo, r.y);
    if (r.d < 1) r.d = 1;
    if (r.d > dm) r.d = dm;
    if (r.w > 6) r.w = 0;
    if (r.h > 23) r.h = 23;
    if (r.mi > 59) r.mi = 59;
    if (r.s > 59) r.s = 59;
    return r;
  endfunction

  function automatic tm_t advance(tm_t t);
    tm_t r = t;
    int sod = t.h * 3600 + t.mi * 60 + t.s + 1;
    if (sod < 86400) begin
      r.h = sod / 3600; r.mi = (sod / 60) % 60; r.s = sod % 60;
    end else begin
      r.h = 0; r.mi = 0; r.s = 0;
      r.w = (t.w + 1) % 7;
      r.d = t.d + 1;
      if (r.d > mdays(t.mo, t.y)) begin
        r.d = 1;
        r.mo = t.mo + 1;
        if (r.mo > 12) begin
          r.mo = 1;
          r.y = (t.y + 1) % 32768;
        end
      end
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  function automatic tm_t dut_tm();
    tm_t t;
    t.y = int'(year); t.mo = int'(month); t.d = int'(day); t.w = int'(week);
    t.h = int'(hour); t.mi = int'(min); t.s = int'(sec);
    return t;
  endfunction

  task automatic check_tm(input string nm, input tm_t exp);
    tm_t got;
    got = dut_tm();
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d-%0d-%0d w%0d %0d:%0d:%0d, expected %0d-%0d-%0d w%0d %0d:%0d:%0d",
               nm, got.y, got.mo, got.d, got.w, got.h, got.mi, got.s,
               exp.y, exp.mo, exp.d, exp.w, exp.h, exp.mi, exp.s);
    end
  endtask

  task automatic check_tick(input string nm, input logic exp);
    n_vec++;
    if (sec_tick !== exp) begin
      n_err++;
      $display("FAIL %s: sec_tick got %b, expected %b", nm, sec_tick, exp);
    end
  endtask

  task automatic drive_load(input tm_t t);
    year_d = 15'(t.y); month_d = 4'(t.mo); day_d = 5'(t.d); week_d = 4'(t.w);
    hour_d = 6'(t.h); min_d = 6'(t.mi); sec_d = 6'(t.s);
    load = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic tm_t rand_tm();
    tm_t t;
    int ysel = int'($urandom_range(0, 6));
    case (ysel)
      0: t.y = 1900;  1: t.y = 2000;  2: t.y = 2100;  3: t.y = 2024;
      4: t.y = 32767; default: t.y = int'($urandom_range(0, 32767));
    endcase
    t.mo = int'($urandom_range(0, 15));
    t.d  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(27, 31));
    t.w  = int'($urandom_range(0, 15));
    t.h  = ($urandom_range(0, 1) == 0) ? 23 : int'($urandom_range(0, 63));
    t.mi = ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 63));
    t.s  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(57, 63)) : int'($urandom_range(0, 63));
    return t;
  endfunction

  vec_t vt [11];
  tm_t  m;
  int   ps;
  logic exp_tick;

  initial begin
    vt[0]  = '{mk(2023,12,31,0,23,59,59), mk(2023,12,31,0,23,59,59), mk(2024,1,1,1,0,0,0)};
    vt[1]  = '{mk(2024,2,28,3,23,59,59),  mk(2024,2,28,3,23,59,59),  mk(2024,2,29,4,0,0,0)};
    vt[2]  = '{mk(1900,2,28,3,23,59,59),  mk(1900,2,28,3,23,59,59),  mk(1900,3,1,4,0,0,0)};
    vt[3]  = '{mk(2000,2,28,1,23,59,59),  mk(2000,2,28,1,23,59,59),  mk(2000,2,29,2,0,0,0)};
    vt[4]  = '{mk(2023,13,31,9,30,61,63), mk(2023,12,31,0,23,59,59), mk(2024,1,1,1,0,0,0)};
    vt[5]  = '{mk(2023,2,30,2,10,20,30),  mk(2023,2,28,2,10,20,30),  mk(2023,2,28,2,10,20,31)};
    vt[6]  = '{mk(32767,12,31,5,23,59,59), mk(32767,12,31,5,23,59,59), mk(0,1,1,6,0,0,0)};
    vt[7]  = '{mk(2021,0,0,3,5,59,59),    mk(2021,1,1,3,5,59,59),    mk(2021,1,1,3,6,0,0)};
    vt[8]  = '{mk(2023,4,30,6,23,59,59),  mk(2023,4,30,6,23,59,59),  mk(2023,5,1,0,0,0,0)};
    vt[9]  = '{mk(2024,2,29,4,23,59,59),  mk(2024,2,29,4,23,59,59),  mk(2024,3,1,5,0,0,0)};
    vt[10] = '{mk(2023,6,15,4,12,59,59),  mk(2023,6,15,4,12,59,59),  mk(2023,6,15,4,13,0,0)};

    rst_n = 1'b0; load = 1'b0; run = 1'b1;
    year_d = '0; month_d = '0; day_d = '0; week_d = '0; hour_d = '0; min_d = '0; sec_d = '0;

    // Reset state, then the first tick four cycles after release.
    step(2);
    check_tm("reset_values", mk(2000,1,1,6,0,0,0));
    check_tick("reset_tick", 1'b0);
    rst_n = 1'b1;
    step(3);
    check_tm("pre_first_tick", mk(2000,1,1,6,0,0,0));
    check_tick("pre_first_tick", 1'b0);
    step(1);
    check_tm("first_tick", mk(2000,1,1,6,0,0,1));
    check_tick("first_tick", 1'b1);
    step(1);
    check_tick("first_tick_single", 1'b0);

    // Table: load, hold for three cycles, then exactly one advance.
    for (int i = 0; i < 11; i++) begin
      drive_load(vt[i].ld);
      step(1);
      load = 1'b0;
      check_tm($sformatf("vec%0d_cap", i), vt[i].cap);
      check_tick($sformatf("vec%0d_cap_tick", i), 1'b0);
      step(3);
      check_tm($sformatf("vec%0d_hold", i), vt[i].cap);
      step(1);
      check_tm($sformatf("vec%0d_adv", i), vt[i].adv);
      check_tick($sformatf("vec%0d_adv_tick", i), 1'b1);
    end

    // Load collides with the terminal count: load wins, no tick.
    drive_load(mk(2022,5,10,2,8,0,0));
    step(1);
    load = 1'b0;
    step(3);
    check_tm("tc_pre", mk(2022,5,10,2,8,0,0));
    drive_load(mk(2023,12,31,0,23,59,59));
    step(1);
    load = 1'b0;
    check_tm("tc_load_wins", mk(2023,12,31,0,23,59,59));
    check_tick("tc_no_tick", 1'b0);
    step(3);
    check_tm("tc_hold", mk(2023,12,31,0,23,59,59));
    check_tick("tc_hold_tick", 1'b0);
    step(1);
    check_tm("tc_next_adv", mk(2024,1,1,1,0,0,0));
    check_tick("tc_next_tick", 1'b1);

    // run=0 freezes prescaler and time; counting resumes from the held count.
    drive_load(mk(2023,6,15,4,12,0,0));
    step(1);
    load = 1'b0;
    step(2);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_tm($sformatf("frozen%0d", i), mk(2023,6,15,4,12,0,0));
      check_tick($sformatf("frozen%0d_tick", i), 1'b0);
    end
    run = 1'b1;
    step(1);
    check_tm("resume_pre", mk(2023,6,15,4,12,0,0));
    check_tick("resume_pre_tick", 1'b0);
    step(1);
    check_tm("resume_adv", mk(2023,6,15,4,12,0,1));
    check_tick("resume_tick", 1'b1);

    // Asynchronous reset between edges, while sec_tick is high.
    #2 rst_n = 1'b0;
    #1;
    check_tm("async_reset", mk(2000,1,1,6,0,0,0));
    check_tick("async_reset_tick", 1'b0);
    step(1);
    rst_n = 1'b1;

    // Randomized run against the reference model.
    ps = 0;
    m = mk(2000,1,1,6,0,0,0);
    for (int i = 0; i < 1500; i++) begin
      bit do_load;
      tm_t t;
      do_load = (i == 0) || ($urandom_range(0, 9) == 0);
      run = ($urandom_range(0, 7) != 0);
      if (do_load) begin
        t = rand_tm();
        drive_load(t);
        m = sanitize(t);
        ps = 0;
        exp_tick = 1'b0;
      end else begin
        load = 1'b0;
        exp_tick = 1'b0;
        if (run) begin
          if (ps == CLK_HZ - 1) begin
            ps = 0;
            m = advance(m);
            exp_tick = 1'b1;
          end else begin
            ps++;
          end
        end
      end
      step(1);
      check_tm($sformatf("rand%0d", i), m);
      check_tick($sformatf("rand%0d_tick", i), exp_tick);
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
